// File: rtl/bus_arbiter.sv
// bus_arbiter: shares one memory port between the fetch and MEM-stage ports.
// Ties in IDLE alternate between requesters using the last granted side, and a
// per-transaction counter forces completion with bus_err when memory never
// acknowledges.
module bus_arbiter #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        inst_req,
    input  logic [31:0] inst_addr,
    output logic [31:0] inst_rdata,
    output logic        inst_ready,
    input  logic        data_req,
    input  logic [3:0]  data_wen,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic [31:0] data_rdata,
    output logic        data_ready,
    output logic        mem_req,
    output logic [3:0]  mem_wen,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic        stall_req,
    output logic        bus_err
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_I_BUSY = 2'd1,
        ST_D_BUSY = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

    // Value the counter holds in the last BUSY cycle before a forced completion.
    localparam logic [7:0] LP_CNT_LAST = 8'(TIMEOUT - 32'd1);

    state_t      r_state, w_state;
    logic        r_last_d, w_last_d;     // 1: data side was granted last
    logic [7:0]  r_cnt, w_cnt;
    logic        r_mem_req, w_mem_req;
    logic [3:0]  r_mem_wen, w_mem_wen;
    logic [31:0] r_mem_addr, w_mem_addr;
    logic [31:0] r_mem_wdata, w_mem_wdata;
    logic [31:0] r_inst_rdata, w_inst_rdata;
    logic [31:0] r_data_rdata, w_data_rdata;
    logic        r_inst_ready, w_inst_ready;
    logic        r_data_ready, w_data_ready;
    logic        r_bus_err, w_bus_err;

    // Next-state and next-output logic; every register holds unless changed below.
    always_comb begin
        w_state      = r_state;
        w_last_d     = r_last_d;
        w_cnt        = r_cnt;
        w_mem_req    = r_mem_req;
        w_mem_wen    = r_mem_wen;
        w_mem_addr   = r_mem_addr;
        w_mem_wdata  = r_mem_wdata;
        w_inst_rdata = r_inst_rdata;
        w_data_rdata = r_data_rdata;
        w_inst_ready = 1'b0;
        w_data_ready = 1'b0;
        w_bus_err    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // Data wins unless both request and data had the previous grant.
                if (data_req && (!inst_req || !r_last_d)) begin
                    w_state     = ST_D_BUSY;
                    w_last_d    = 1'b1;
                    w_cnt       = 8'd0;
                    w_mem_req   = 1'b1;
                    w_mem_wen   = data_wen;
                    w_mem_addr  = data_addr;
                    w_mem_wdata = data_wdata;
                end else if (inst_req) begin
                    w_state     = ST_I_BUSY;
                    w_last_d    = 1'b0;
                    w_cnt       = 8'd0;
                    w_mem_req   = 1'b1;
                    w_mem_wen   = 4'b0000;
                    w_mem_addr  = inst_addr;
                    w_mem_wdata = 32'h0000_0000;
                end else begin
                    w_state = ST_IDLE;
                end
            end
            ST_I_BUSY, ST_D_BUSY: begin
                if (mem_ack) begin
                    w_state   = ST_RESP;
                    w_mem_req = 1'b0;
                    if (r_state == ST_D_BUSY) begin
                        w_data_rdata = mem_rdata;
                        w_data_ready = 1'b1;
                    end else begin
                        w_inst_rdata = mem_rdata;
                        w_inst_ready = 1'b1;
                    end
                end else if (r_cnt >= LP_CNT_LAST) begin
                    // Memory never answered: complete with zero data and flag it.
                    w_state   = ST_RESP;
                    w_mem_req = 1'b0;
                    w_bus_err = 1'b1;
                    if (r_state == ST_D_BUSY) begin
                        w_data_rdata = 32'h0000_0000;
                        w_data_ready = 1'b1;
                    end else begin
                        w_inst_rdata = 32'h0000_0000;
                        w_inst_ready = 1'b1;
                    end
                end else begin
                    w_cnt = r_cnt + 8'd1;
                end
            end
            ST_RESP: begin
                w_state = ST_IDLE;
            end
            default: begin
                w_state   = ST_IDLE;
                w_mem_req = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_last_d     <= 1'b0;
            r_cnt        <= 8'd0;
            r_mem_req    <= 1'b0;
            r_mem_wen    <= 4'b0000;
            r_mem_addr   <= 32'h0000_0000;
            r_mem_wdata  <= 32'h0000_0000;
            r_inst_rdata <= 32'h0000_0000;
            r_data_rdata <= 32'h0000_0000;
            r_inst_ready <= 1'b0;
            r_data_ready <= 1'b0;
            r_bus_err    <= 1'b0;
        end else begin
            r_state      <= w_state;
            r_last_d     <= w_last_d;
            r_cnt        <= w_cnt;
            r_mem_req    <= w_mem_req;
            r_mem_wen    <= w_mem_wen;
            r_mem_addr   <= w_mem_addr;
            r_mem_wdata  <= w_mem_wdata;
            r_inst_rdata <= w_inst_rdata;
            r_data_rdata <= w_data_rdata;
            r_inst_ready <= w_inst_ready;
            r_data_ready <= w_data_ready;
            r_bus_err    <= w_bus_err;
        end
    end

    assign inst_rdata = r_inst_rdata;
    assign inst_ready = r_inst_ready;
    assign data_rdata = r_data_rdata;
    assign data_ready = r_data_ready;
    assign mem_req    = r_mem_req;
    assign mem_wen    = r_mem_wen;
    assign mem_addr   = r_mem_addr;
    assign mem_wdata  = r_mem_wdata;
    assign bus_err    = r_bus_err;

    // A requester stalls the pipeline until its completion pulse is visible.
    assign stall_req  = (inst_req & ~r_inst_ready) | (data_req & ~r_data_ready);

endmodule

// File: tb/tb_bus_arbiter.sv
// Testbench for bus_arbiter: directed scenarios with literal expectations plus a
// transaction-level model compared against every output on every falling edge.
module tb_bus_arbiter;

    localparam int unsigned TO = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        inst_req = 1'b0;
    logic [31:0] inst_addr = 32'h0;
    logic [31:0] inst_rdata;
    logic        inst_ready;
    logic        data_req = 1'b0;
    logic [3:0]  data_wen = 4'h0;
    logic [31:0] data_addr = 32'h0;
    logic [31:0] data_wdata = 32'h0;
    logic [31:0] data_rdata;
    logic        data_ready;
    logic        mem_req;
    logic [3:0]  mem_wen;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = 32'h0;
    logic        mem_ack = 1'b0;
    logic        stall_req;
    logic        bus_err;

    bus_arbiter #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .inst_req(inst_req), .inst_addr(inst_addr), .inst_rdata(inst_rdata), .inst_ready(inst_ready),
        .data_req(data_req), .data_wen(data_wen), .data_addr(data_addr), .data_wdata(data_wdata),
        .data_rdata(data_rdata), .data_ready(data_ready),
        .mem_req(mem_req), .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack), .stall_req(stall_req), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- memory responder ----------------
    bit          auto_ack  = 1'b0;
    int          ack_delay = 0;
    int          rsp_cnt   = 0;
    bit          rd_ovr_en = 1'b0;
    logic [31:0] rd_ovr    = 32'h0;

    initial forever begin
        @(posedge clk);
        #1;
        if (auto_ack) begin
            if (mem_req) begin
                if (rsp_cnt == ack_delay) begin
                    mem_ack   = 1'b1;
                    mem_rdata = rd_ovr_en ? rd_ovr : (mem_addr ^ 32'h5A5A_A5A5);
                end else begin
                    mem_ack = 1'b0;
                    rsp_cnt++;
                end
            end else begin
                mem_ack = 1'b0;
                rsp_cnt = 0;
            end
        end
    end

    // ---------------- transaction-level model ----------------
    // A transaction is: granted side, latched request, age in BUSY cycles, and a
    // one-cycle response phase. Inputs are snapshotted at each falling edge, which
    // equals what the next rising edge samples.
    bit          s_rst = 1'b1, s_ireq = 1'b0, s_dreq = 1'b0, s_ack = 1'b0;
    logic [31:0] s_iaddr = 32'h0, s_daddr = 32'h0, s_dwdata = 32'h0, s_rdata = 32'h0;
    logic [3:0]  s_dwen = 4'h0;

    bit          m_busy = 1'b0, m_resp = 1'b0, m_side_d = 1'b0, m_last_d = 1'b0, m_err = 1'b0;
    int          m_age = 0;
    logic [31:0] m_addr = 32'h0, m_wdata = 32'h0, m_ir = 32'h0, m_dr = 32'h0;
    logic [3:0]  m_wen = 4'h0;

    initial forever begin
        @(negedge clk);
        if (s_rst) begin
            m_busy = 1'b0; m_resp = 1'b0; m_side_d = 1'b0; m_last_d = 1'b0; m_err = 1'b0;
            m_age = 0; m_addr = 32'h0; m_wdata = 32'h0; m_wen = 4'h0; m_ir = 32'h0; m_dr = 32'h0;
        end else if (m_resp) begin
            m_resp = 1'b0; m_busy = 1'b0; m_err = 1'b0;
        end else if (m_busy) begin
            m_age++;
            if (s_ack) begin
                m_resp = 1'b1;
                if (m_side_d) m_dr = s_rdata; else m_ir = s_rdata;
            end else if (m_age == int'(TO)) begin
                m_resp = 1'b1;
                m_err  = 1'b1;
                if (m_side_d) m_dr = 32'h0; else m_ir = 32'h0;
            end
        end else if (s_ireq || s_dreq) begin
            m_side_d = s_dreq && !(s_ireq && m_last_d);
            m_last_d = m_side_d;
            m_busy   = 1'b1;
            m_age    = 0;
            m_addr   = m_side_d ? s_daddr  : s_iaddr;
            m_wen    = m_side_d ? s_dwen   : 4'h0;
            m_wdata  = m_side_d ? s_dwdata : 32'h0;
        end
        chk("m_mem_req",    32'(mem_req),    32'(m_busy && !m_resp));
        chk("m_mem_wen",    32'(mem_wen),    32'(m_wen));
        chk("m_mem_addr",   mem_addr,        m_addr);
        chk("m_mem_wdata",  mem_wdata,       m_wdata);
        chk("m_inst_ready", 32'(inst_ready), 32'(m_resp && !m_side_d));
        chk("m_data_ready", 32'(data_ready), 32'(m_resp && m_side_d));
        chk("m_bus_err",    32'(bus_err),    32'(m_resp && m_err));
        chk("m_inst_rdata", inst_rdata,      m_ir);
        chk("m_data_rdata", data_rdata,      m_dr);
        chk("m_stall_req",  32'(stall_req),
            32'((inst_req && !(m_resp && !m_side_d)) || (data_req && !(m_resp && m_side_d))));
        s_rst = rst; s_ireq = inst_req; s_dreq = data_req; s_ack = mem_ack; s_rdata = mem_rdata;
        s_iaddr = inst_addr; s_daddr = data_addr; s_dwen = data_wen; s_dwdata = data_wdata;
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Serve pending requests, dropping each one when its ready pulse is seen,
    // then idle two cycles to catch any extra pulse.
    task automatic run_until_done(input int max_c, output int cyc, output int n_mr,
                                  output int n_ir, output int n_dr, output int n_err);
        cyc = 0; n_mr = 0; n_ir = 0; n_dr = 0; n_err = 0;
        while ((inst_req || data_req) && cyc < max_c) begin
            tick();
            cyc++;
            if (mem_req)    n_mr++;
            if (bus_err)    n_err++;
            if (inst_ready) begin n_ir++; inst_req = 1'b0; end
            if (data_ready) begin n_dr++; data_req = 1'b0; end
        end
        if (inst_req || data_req) begin
            chk("wait_bound", 32'd0, 32'd1);
            inst_req = 1'b0;
            data_req = 1'b0;
        end
        repeat (2) begin
            tick();
            if (inst_ready) n_ir++;
            if (data_ready) n_dr++;
            if (bus_err)    n_err++;
        end
    endtask

    int cyc, n_mr, n_ir, n_dr, n_err, g, nst;
    logic [31:0] gaddr [3];
    logic [3:0]  gwen0;
    bit          prev_mr, got;

    bit          t_i   [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    bit          t_d   [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    logic [3:0]  t_wen [5] = '{4'b0000, 4'b1100, 4'b0001, 4'b0000, 4'b1111};
    int          t_dly [5] = '{1, 2, 0, 3, 1};

    initial begin
        rst = 1'b1;
        repeat (2) tick();
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_inst_rdata", inst_rdata, 32'h0);
        rst = 1'b0;
        tick();

        // Single fetch, ack one cycle after mem_req.
        auto_ack = 1'b1; ack_delay = 1; rd_ovr_en = 1'b1; rd_ovr = 32'h2408_0001;
        inst_addr = 32'hBFC0_0000; inst_req = 1'b1;
        run_until_done(20, cyc, n_mr, n_ir, n_dr, n_err);
        chk("fetch_latency", 32'(cyc), 32'd3);
        chk("fetch_memreq_cycles", 32'(n_mr), 32'd2);
        chk("fetch_ready_pulses", 32'(n_ir), 32'd1);
        chk("fetch_data_ready", 32'(n_dr), 32'd0);
        chk("fetch_rdata", inst_rdata, 32'h2408_0001);
        chk("fetch_mem_wen", 32'(mem_wen), 32'd0);
        chk("fetch_mem_addr", mem_addr, 32'hBFC0_0000);
        rd_ovr_en = 1'b0;

        // Simultaneous requests after reset: data, fetch, data.
        rst = 1'b1; repeat (2) tick(); rst = 1'b0;
        ack_delay = 0;
        inst_addr = 32'h0040_0000; inst_req = 1'b1;
        data_addr = 32'h8000_0010; data_wen = 4'b0011; data_wdata = 32'h0000_5555; data_req = 1'b1;
        g = 0; prev_mr = 1'b0; gwen0 = 4'h0;
        for (int c = 0; c < 40 && g < 3; c++) begin
            tick();
            if (mem_req && !prev_mr) begin
                gaddr[g] = mem_addr;
                if (g == 0) gwen0 = mem_wen;
                g++;
            end
            prev_mr = mem_req;
        end
        inst_req = 1'b0; data_req = 1'b0;
        repeat (4) tick();
        chk("tie_grants", 32'(g), 32'd3);
        chk("tie1_data", gaddr[0], 32'h8000_0010);
        chk("tie1_wen", 32'(gwen0), 32'b0011);
        chk("tie2_inst", gaddr[1], 32'h0040_0000);
        chk("tie3_data", gaddr[2], 32'h8000_0010);

        // Store with inputs changing during BUSY.
        ack_delay = 3;
        data_addr = 32'h8000_0100; data_wen = 4'b1111; data_wdata = 32'hDEAD_BEEF; data_req = 1'b1;
        n_mr = 0; n_dr = 0;
        for (int c = 0; c < 20 && data_req; c++) begin
            tick();
            if (mem_req) begin
                n_mr++;
                chk("store_wdata_hold", mem_wdata, 32'hDEAD_BEEF);
                chk("store_addr_hold", mem_addr, 32'h8000_0100);
                if (n_mr == 1) begin
                    data_wdata = 32'h0; data_addr = 32'h1234_5678; data_wen = 4'b0001;
                end
            end
            if (data_ready) begin n_dr++; data_req = 1'b0; end
        end
        repeat (3) begin tick(); if (data_ready) n_dr++; end
        chk("store_memreq_cycles", 32'(n_mr), 32'd4);
        chk("store_ready_pulses", 32'(n_dr), 32'd1);

        // Timeout: memory never acknowledges.
        auto_ack = 1'b0; mem_ack = 1'b0;
        data_addr = 32'h8000_0200; data_wen = 4'b0000; data_req = 1'b1;
        run_until_done(20, cyc, n_mr, n_ir, n_dr, n_err);
        chk("to_memreq_cycles", 32'(n_mr), 32'd4);
        chk("to_ready", 32'(n_dr), 32'd1);
        chk("to_bus_err", 32'(n_err), 32'd1);
        chk("to_latency", 32'(cyc), 32'd5);
        chk("to_rdata", data_rdata, 32'h0);

        // Stray ack in IDLE is ignored.
        mem_ack = 1'b1; mem_rdata = 32'hFFFF_FFFF;
        tick();
        mem_ack = 1'b0;
        tick();
        chk("stray_inst_ready", 32'(inst_ready), 32'd0);
        chk("stray_data_ready", 32'(data_ready), 32'd0);
        chk("stray_data_rdata", data_rdata, 32'h0);

        // Reset during I_BUSY, ack arrives the cycle after.
        inst_addr = 32'hBFC0_0010; inst_req = 1'b1;
        tick();
        chk("rb_busy", 32'(mem_req), 32'd1);
        rst = 1'b1; inst_req = 1'b0;
        tick();
        chk("rb_memreq_cleared", 32'(mem_req), 32'd0);
        rst = 1'b0; mem_ack = 1'b1; mem_rdata = 32'h1111_1111;
        tick();
        mem_ack = 1'b0;
        chk("rb_no_ready", 32'(inst_ready), 32'd0);
        chk("rb_rdata", inst_rdata, 32'h0);
        tick();
        chk("rb_no_ready2", 32'(inst_ready), 32'd0);
        auto_ack = 1'b1; ack_delay = 0;
        inst_addr = 32'hBFC0_0014; inst_req = 1'b1;
        run_until_done(20, cyc, n_mr, n_ir, n_dr, n_err);
        chk("rb_idle_after", 32'(cyc), 32'd2);

        // Stall: fetch pending three BUSY cycles.
        ack_delay = 2;
        inst_addr = 32'hBFC0_0020; inst_req = 1'b1;
        #1;
        chk("stall_idle", 32'(stall_req), 32'd1);
        nst = 0; got = 1'b0;
        for (int c = 0; c < 20 && !got; c++) begin
            tick();
            if (inst_ready) begin
                chk("stall_at_ready", 32'(stall_req), 32'd0);
                got = 1'b1;
            end else begin
                chk("stall_pending", 32'(stall_req), 32'd1);
                nst++;
            end
        end
        chk("stall_cycles", 32'(nst), 32'd3);
        inst_req = 1'b0;
        repeat (2) tick();

        // Mixed vectors.
        for (int k = 0; k < 5; k++) begin
            ack_delay  = t_dly[k];
            inst_addr  = 32'hBFC0_0100 + 32'(k * 4);
            data_addr  = 32'h8000_0300 + 32'(k * 4);
            data_wen   = t_wen[k];
            data_wdata = 32'hA000_0000 | 32'(k);
            inst_req   = t_i[k];
            data_req   = t_d[k];
            run_until_done(40, cyc, n_mr, n_ir, n_dr, n_err);
            chk("mix_inst_ready", 32'(n_ir), 32'(t_i[k]));
            chk("mix_data_ready", 32'(n_dr), 32'(t_d[k]));
            chk("mix_bus_err", 32'(n_err), 32'd0);
        end

        repeat (2) tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

endmodule
